// File: rtl/index_vec_assembler_pkg.sv
// Shared width helpers for the index/mask conversion blocks.
package index_vec_assembler_pkg;

    function automatic int unsigned width_for(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/index_vec_assembler_onehot.sv
// Combinational index-to-one-hot decoder with an out-of-range flag for non-power-of-two widths.
module index_onehot_decoder #(
    parameter int unsigned W     = 16,
    parameter int unsigned IDX_W = 4
) (
    input  logic [IDX_W-1:0] index,
    output logic [W-1:0]     onehot,
    output logic             out_of_range
);

    localparam logic [IDX_W:0] WidthLimit = (IDX_W + 1)'(W);

    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < W; i++) begin
            onehot[i] = ({1'b0, index} == (IDX_W + 1)'(i));
        end
        out_of_range = ({1'b0, index} >= WidthLimit);
    end

endmodule

// File: rtl/index_vec_assembler.sv
// Rebuilds a W-bit flag vector from a stream of bit indices, one vector per in_last-delimited batch.
module index_vec_assembler
    import index_vec_assembler_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned IDX_W = width_for(W),
    parameter int unsigned CNT_W = width_for(W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_index,
    input  logic             in_none,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_vec,
    output logic [CNT_W-1:0] out_count,
    output logic             out_err
);

    typedef enum logic [0:0] {StAccum, StHold} state_e;

    state_e             state_q, state_d;
    logic [W-1:0]       acc_vec_q, acc_vec_d;
    logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
    logic               acc_err_q, acc_err_d;
    logic               valid_q, valid_d;
    logic [W-1:0]       vec_q, vec_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic [W-1:0]       onehot;
    logic               out_of_range;
    logic               dup;
    logic [W-1:0]       merged_vec;
    logic [CNT_W-1:0]   merged_cnt;
    logic               merged_err;
    logic               accept;
    logic               slot_free;

    index_onehot_decoder #(
        .W     (W),
        .IDX_W (IDX_W)
    ) u_decoder (
        .index        (in_index),
        .onehot       (onehot),
        .out_of_range (out_of_range)
    );

    assign dup       = |(acc_vec_q & onehot);
    assign in_ready  = (state_q == StAccum);
    assign accept    = in_valid & in_ready;
    assign slot_free = !valid_q | out_ready;

    always_comb begin
        merged_vec = acc_vec_q;
        merged_cnt = acc_cnt_q;
        merged_err = acc_err_q;
        if (!in_none) begin
            if (out_of_range || dup) begin
                merged_err = 1'b1;
            end else begin
                merged_vec = acc_vec_q | onehot;
                merged_cnt = acc_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_vec_d = acc_vec_q;
        acc_cnt_d = acc_cnt_q;
        acc_err_d = acc_err_q;
        valid_d   = valid_q;
        vec_d     = vec_q;
        cnt_d     = cnt_q;
        err_d     = err_q;

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            StAccum: begin
                if (accept) begin
                    if (in_last && slot_free) begin
                        valid_d   = 1'b1;
                        vec_d     = merged_vec;
                        cnt_d     = merged_cnt;
                        err_d     = merged_err;
                        acc_vec_d = '0;
                        acc_cnt_d = '0;
                        acc_err_d = 1'b0;
                    end else begin
                        // A stalled last beat parks the finished batch in the accumulator.
                        acc_vec_d = merged_vec;
                        acc_cnt_d = merged_cnt;
                        acc_err_d = merged_err;
                        if (in_last) begin
                            state_d = StHold;
                        end
                    end
                end
            end
            StHold: begin
                if (slot_free) begin
                    valid_d   = 1'b1;
                    vec_d     = acc_vec_q;
                    cnt_d     = acc_cnt_q;
                    err_d     = acc_err_q;
                    acc_vec_d = '0;
                    acc_cnt_d = '0;
                    acc_err_d = 1'b0;
                    state_d   = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StAccum;
            acc_vec_q <= '0;
            acc_cnt_q <= '0;
            acc_err_q <= 1'b0;
            valid_q   <= 1'b0;
            vec_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_vec_q <= acc_vec_d;
            acc_cnt_q <= acc_cnt_d;
            acc_err_q <= acc_err_d;
            valid_q   <= valid_d;
            vec_q     <= vec_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign out_vec   = vec_q;
    assign out_count = cnt_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_index_vec_assembler.sv
// Scoreboard bench: a W=16 instance checked through an expected-result queue, plus a W=12 instance.
module tb_index_vec_assembler;

    typedef struct {
        logic [15:0] vec;
        int          cnt;
        bit          err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_none, in_last;
    logic [3:0]  in_index;
    logic        out_valid, out_ready, out_err;
    logic [15:0] out_vec;
    logic [4:0]  out_count;

    logic        s_in_valid, s_in_ready, s_in_none, s_in_last;
    logic [3:0]  s_in_index;
    logic        s_out_valid, s_out_ready, s_out_err;
    logic [11:0] s_out_vec;
    logic [3:0]  s_out_count;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];

    logic [15:0] m_vec;
    int          m_cnt;
    bit          m_err;

    always #5 clk = ~clk;

    index_vec_assembler #(.W(16)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_index  (in_index),
        .in_none   (in_none),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .out_count (out_count),
        .out_err   (out_err)
    );

    index_vec_assembler #(.W(12)) u_dut12 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_index  (s_in_index),
        .in_none   (s_in_none),
        .in_last   (s_in_last),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_vec   (s_out_vec),
        .out_count (s_out_count),
        .out_err   (s_out_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Drives one beat on the W=16 instance, updates the reference model, returns #1 after acceptance.
    task automatic beat(input int idx, input bit none, input bit last);
        bit accepted = 1'b0;
        in_valid = 1'b1;
        in_index = 4'(idx);
        in_none  = none;
        in_last  = last;
        for (int n = 0; n < 50 && !accepted; n++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                accepted = 1'b1;
            end
        end
        if (!accepted) check("beat_accept_timeout", 0, 1);
        if (!none) begin
            if (idx >= 16 || m_vec[idx]) m_err = 1'b1;
            else begin
                m_vec[idx] = 1'b1;
                m_cnt++;
            end
        end
        if (last) begin
            exp_q.push_back('{vec: m_vec, cnt: m_cnt, err: m_err});
            m_vec = '0;
            m_cnt = 0;
            m_err = 1'b0;
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic beat12(input int idx, input bit none);
        s_in_valid = 1'b1;
        s_in_index = 4'(idx);
        s_in_none  = none;
        s_in_last  = 1'b1;
        @(negedge clk);
        check("w12_in_ready", 32'(s_in_ready), 1);
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'(out_vec), 32'hffff_ffff);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_vec", 32'(out_vec), 32'(e.vec));
                check("sb_count", 32'(out_count), 32'(e.cnt));
                check("sb_err", 32'(out_err), 32'(e.err));
            end
        end
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_index = '0; in_none = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_index = '0; s_in_none = 1'b0; s_in_last = 1'b0;
        s_out_ready = 1'b1;
        m_vec = '0; m_cnt = 0; m_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_vec", 32'(out_vec), 0);
        check("rst_out_count", 32'(out_count), 0);
        check("rst_out_err", 32'(out_err), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // {3, 7, 0 last}
        beat(3, 0, 0); beat(7, 0, 0); beat(0, 0, 1);
        check("t1_valid", 32'(out_valid), 1);
        check("t1_vec", 32'(out_vec), 32'h0089);
        check("t1_count", 32'(out_count), 3);
        check("t1_err", 32'(out_err), 0);

        // Duplicate index
        beat(5, 0, 0); beat(5, 0, 1);
        check("dup_vec", 32'(out_vec), 32'h0020);
        check("dup_count", 32'(out_count), 1);
        check("dup_err", 32'(out_err), 1);

        // none-only batch and a none beat mixed into a batch
        beat(0, 1, 1);
        check("none_vec", 32'(out_vec), 0);
        check("none_err", 32'(out_err), 0);
        beat(11, 0, 0); beat(0, 1, 0); beat(15, 0, 1);
        check("mixed_vec", 32'(out_vec), 32'h8800);

        // W=12 out-of-range and none-only
        beat12(13, 0);
        check("w12_oor_valid", 32'(s_out_valid), 1);
        check("w12_oor_vec", 32'(s_out_vec), 0);
        check("w12_oor_count", 32'(s_out_count), 0);
        check("w12_oor_err", 32'(s_out_err), 1);
        beat12(0, 1);
        check("w12_none_vec", 32'(s_out_vec), 0);
        check("w12_none_count", 32'(s_out_count), 0);
        check("w12_none_err", 32'(s_out_err), 0);
        beat12(11, 0);
        check("w12_top_vec", 32'(s_out_vec), 32'h800);

        // Backpressure: A held on output, B parked in HOLD
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        beat(2, 0, 1);
        check("bp_a_valid", 32'(out_valid), 1);
        beat(9, 0, 1);
        check("bp_hold_in_ready", 32'(in_ready), 0);
        check("bp_a_vec", 32'(out_vec), 32'h0004);
        @(posedge clk);
        #1;
        check("bp_a_stable_vec", 32'(out_vec), 32'h0004);
        check("bp_a_stable_valid", 32'(out_valid), 1);
        check("bp_hold_in_ready2", 32'(in_ready), 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_b_valid", 32'(out_valid), 1);
        check("bp_b_vec", 32'(out_vec), 32'h0200);
        check("bp_in_ready_back", 32'(in_ready), 1);
        @(posedge clk);
        #1;

        // Back-to-back single-beat batches with no bubble
        for (int i = 0; i < 4; i++) begin
            beat(i, 0, 1);
            check("b2b_valid", 32'(out_valid), 1);
            check("b2b_vec", 32'(out_vec), 32'(1) << i);
        end
        @(posedge clk);
        #1;
        check("b2b_drained", 32'(out_valid), 0);

        // Mid-batch reset
        beat(4, 0, 0); beat(6, 0, 0);
        rst = 1'b1;
        m_vec = '0; m_cnt = 0; m_err = 1'b0;
        @(negedge clk);
        check("mrst_out_valid", 32'(out_valid), 0);
        check("mrst_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        beat(1, 0, 1);
        check("mrst_vec", 32'(out_vec), 32'h0002);
        check("mrst_count", 32'(out_count), 1);

        for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(posedge clk);
        check("sb_drained", 32'(exp_q.size()), 0);
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/index_vec_assembler.md
# index_vec_assembler

Rebuilds a W-bit flag vector from a stream of bit indices, one index per beat, with batches delimited by `in_last`. It is the inverse of the priority-encoding stage: match and hash-bank index streams are turned back into bank/slot masks for the downstream scheduler. One batch in produces exactly one vector out. A single output holding register lets the next batch start while the previous vector waits for `out_ready`.

## Interface
- `W`, default 16: output vector width, minimum 2; need not be a power of two.
- `IDX_W`, default `$clog2(W)`: derived index width; not overridden by instantiators.
- `CNT_W`, default `$clog2(W+1)`: derived count width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  input beat accepted when `in_valid & in_ready`.
- `in_index`  in  IDX_W  bit index to set; ignored when `in_none=1`.
- `in_none`  in  1  beat carries no index (an empty-encoder result).
- `in_last`  in  1  final beat of the batch.
- `out_valid`  out  1  assembled vector valid.
- `out_ready`  in  1  downstream accepts when `out_valid & out_ready`.
- `out_vec`  out  W  assembled vector.
- `out_count`  out  CNT_W  number of distinct bits set in `out_vec`.
- `out_err`  out  1  batch contained a duplicate or out-of-range index.

## Operation
- Accumulator registers: `acc_vec[W]`, `acc_cnt[CNT_W]`, `acc_err`.
- FSM has two states.
  - ACCUM: `in_ready=1`.
  - HOLD: `in_ready=0`.
- Merge on an accepted beat with `in_none=0`:
  - Valid index (`in_index < W`) whose bit is clear: set the bit and increment the count.
  - Valid index whose bit is already set: set `err`.
  - `in_index >= W`: set `err` and leave the vector unchanged. This only occurs when W is not a power of two.
- An accepted beat with `in_none=1` is merge-neutral. A batch of only `none` beats yields `out_vec=0`, `out_count=0`, `out_err=0`.
- Accepted beat with `in_last=1` while the output slot is free or draining (`!out_valid | out_ready`):
  - Load the merged result into the output registers and set `out_valid`.
  - Clear the accumulator.
  - Stay in ACCUM.
- Accepted beat with `in_last=1` while the output slot is stalled:
  - Store the merged result in the accumulator.
  - Go to HOLD.
- In HOLD, the edge at which the slot becomes free or draining moves the accumulator into the output registers, clears the accumulator and returns to ACCUM.
- Output handshake without a new load clears `out_valid`. `out_vec`, `out_count` and `out_err` are don't-care while `out_valid=0`, but the implementation clears them on reset.
- Batch length is unbounded. `out_count` cannot overflow because it counts only distinct bits.
- `out_*` signals are stable while `out_valid & !out_ready`.

## Timing
- Reset values: `out_valid=0`, `out_vec=0`, `out_count=0`, `out_err=0`, accumulator 0, state ACCUM, so `in_ready=1`.
- Asserting `rst` mid-batch discards the partial batch and any held or pending output.
- `in_ready` is a function of state only; there is no combinational path from `in_valid` or `out_ready`.
- Latency: last beat accepted at edge t gives `out_valid=1` after edge t when the slot is free. If stalled, `out_valid` appears one edge after the first free/draining cycle.
- Throughput: with `out_ready` held high, single-beat batches are accepted every cycle and produce one vector per cycle.
- Simultaneous events: a last beat and an output handshake in the same cycle reload the output register back-to-back with no bubble.
- In HOLD, at most one completed batch waits in the accumulator. After the transfer edge, `in_ready` returns to 1 in the next cycle.

## Structure
- The ACCUM/HOLD state encoding lives locally in this block.
- `IDX_W` and `CNT_W` are derived locally.
- Shared package: only a `clog2`-style width helper, if the package already has one.
- Sub-module `index_onehot_decoder` (combinational): `in_index` → W-bit one-hot plus `out_of_range` flag. It is reusable by other index-to-mask consumers.

## Test plan
- W=16, batch {3, 7, 0 last}, `out_ready=1` → one cycle after the last beat: `out_vec=16'h0089`, `out_count=3`, `out_err=0`.
- W=16, batch {5, 5 last} → `out_vec=16'h0020`, `out_count=1`, `out_err=1`.
- W=12, batch {13 last} → `out_vec=0`, `out_count=0`, `out_err=1`. Separately, batch {none last} → `out_vec=0`, `out_count=0`, `out_err=0`.
- `out_ready=0`:
  - Batch A {2 last} is presented; then batch B {9 last} is presented.
  - Required: the B beat is accepted, the block enters HOLD and `in_ready=0`, while A (`16'h0004`) stays stable on the output.
  - Raise `out_ready` → A handshakes; B (`16'h0200`) is valid the next cycle; `in_ready=1` again.
- `out_ready=1`, single-beat batches {0}, {1}, {2}, {3} on consecutive cycles → four consecutive `out_valid` cycles: `0001`, `0002`, `0004`, `0008`, with no bubble.
- Mid-batch reset: {4, 6}, then assert `rst`, then release and send {1 last} → `out_vec=16'h0002`, `out_count=1`. While `rst` is high: `out_valid=0` and `in_ready=1`.
